// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic-light front end: cycle timing constants,
// the green-time budget split, the approach index and the demand FSM states.
// No ports (package).
// ---------------------------------------------------------------------------
package traffic_pkg;

    localparam int TCYCLE    = 200;  // total light cycle, ticks
    localparam int TO        = 10;   // orange per approach, ticks
    localparam int TG_MIN    = 20;   // guaranteed green per approach, ticks
    localparam int NUM_APP   = 4;
    localparam int NUM_UNITS = 8;

    // Green budget left after the four orange phases, and the size of one
    // demand-driven unit once every approach has its minimum.
    localparam int G_BUDGET   = TCYCLE - NUM_APP * TO;
    localparam int UNIT_TICKS = (G_BUDGET - NUM_APP * TG_MIN) / NUM_UNITS;

    localparam logic [7:0] TG_DEFAULT = 8'd40;
    localparam logic [7:0] TG_MIN_W8  = 8'(TG_MIN);
    localparam logic [7:0] UNIT_W8    = 8'(UNIT_TICKS);

    typedef enum logic [1:0] {
        N = 2'd0,
        E = 2'd1,
        S = 2'd2,
        W = 2'd3
    } approach_e;

    typedef enum logic [1:0] {
        COUNT  = 2'd0,
        ALLOC  = 2'd1,
        COMMIT = 2'd2
    } tdc_state_e;

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Turns a bouncing push-button into a single one-cycle request pulse.
// The raw input is registered once; a press is accepted on the edge that sees
// the DEB_CYCLES-th consecutive high registered sample, and the detector only
// re-arms after DEB_CYCLES consecutive low registered samples.
//
// Parameters: DEB_CYCLES  stable samples required (2..255)
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset (leaves the detector armed)
//   raw    in   raw button level
//   pulse  out  one-cycle accepted-press pulse
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    localparam logic [7:0] RUN_LAST = 8'(DEB_CYCLES - 1);

    logic       raw_q;
    logic       armed_q;
    logic [7:0] run_q;

    // One run counter serves both directions: while armed it counts high
    // samples (towards a press), while disarmed it counts low samples
    // (towards re-arming). A sample of the other level restarts the run.
    always_ff @(posedge clk) begin
        if (reset) begin
            raw_q   <= 1'b0;
            armed_q <= 1'b1;
            run_q   <= '0;
            pulse   <= 1'b0;
        end else begin
            raw_q <= raw;
            pulse <= 1'b0;
            if (raw_q == armed_q) begin
                if (run_q == RUN_LAST) begin
                    run_q   <= '0;
                    armed_q <= ~armed_q;
                    pulse   <= armed_q;
                end else begin
                    run_q <= run_q + 8'd1;
                end
            end else begin
                run_q <= '0;
            end
        end
    end

endmodule

// File: rtl/traffic_demand_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_demand_ctrl
// Front-end conditioner for the four-way traffic light controller.
//  - Debounces the pedestrian and emergency buttons into one-cycle pulses.
//  - Counts vehicle arrivals per approach over a WIN_LEN-cycle window and, at
//    each window end, splits the spare green budget into 8 units of 10 ticks
//    handed out greedily by weight (weight halves after each win, ties go
//    N, E, S, W). Every approach keeps TG_MIN; an all-zero window yields 40
//    each. Result appears 9 edges after the window-end edge with tg_valid.
//
// Build option: define TDC_ADAPTIVE_EN to build the demand logic. Without it
// TGx are constant 40, tg_valid is 0 and car_x are ignored.
//
// Parameters: DEB_CYCLES (2..255), WIN_LEN (16..65535)
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   ped_raw, em_raw             raw buttons
//   car_n/e/s/w                 vehicle detectors (high while present)
//   ped_button, em_button       one-cycle request pulses
//   TGn/TGe/TGs/TGw [7:0]       green durations in ticks
//   tg_valid                    one-cycle strobe on TGx update
// ---------------------------------------------------------------------------
module traffic_demand_ctrl
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int WIN_LEN    = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ped_raw,
    input  logic       em_raw,
    input  logic       car_n,
    input  logic       car_e,
    input  logic       car_s,
    input  logic       car_w,
    output logic       ped_button,
    output logic       em_button,
    output logic [7:0] TGn,
    output logic [7:0] TGe,
    output logic [7:0] TGs,
    output logic [7:0] TGw,
    output logic       tg_valid
);

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ped (
        .clk   (clk),
        .reset (reset),
        .raw   (ped_raw),
        .pulse (ped_button)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_em (
        .clk   (clk),
        .reset (reset),
        .raw   (em_raw),
        .pulse (em_button)
    );

`ifdef TDC_ADAPTIVE_EN

    localparam logic [15:0] WIN_LAST = 16'(WIN_LEN - 1);

    logic [NUM_APP-1:0] car_now;
    logic [NUM_APP-1:0] car_q;
    logic [NUM_APP-1:0] car_rise;
    logic [7:0]         cnt_q  [NUM_APP];
    logic [7:0]         wgt_q  [NUM_APP];
    logic [7:0]         acc_q  [NUM_APP];
    logic [7:0]         tg_q   [NUM_APP];
    logic [15:0]        win_q;
    logic               win_end;
    logic [2:0]         unit_q;
    logic               all_zero_q;
    logic [1:0]         win_idx;
    logic [7:0]         best_w;
    tdc_state_e         state_q;
    tdc_state_e         state_d;

    assign car_now  = {car_w, car_s, car_e, car_n};
    assign car_rise = car_now & ~car_q;
    assign win_end  = (win_q == WIN_LAST);

    // Heaviest approach; strict '>' keeps the lowest index on ties.
    always_comb begin
        win_idx = 2'd0;
        best_w  = wgt_q[0];
        for (int i = 1; i < NUM_APP; i++) begin
            if (wgt_q[i] > best_w) begin
                best_w  = wgt_q[i];
                win_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COUNT:   if (win_end) state_d = ALLOC;
            ALLOC:   if (unit_q == 3'(NUM_UNITS - 1)) state_d = COMMIT;
            COMMIT:  state_d = COUNT;
            default: state_d = COUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= COUNT;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            car_q    <= '0;
            win_q    <= '0;
            unit_q   <= '0;
            tg_valid <= 1'b0;
            for (int i = 0; i < NUM_APP; i++) begin
                cnt_q[i] <= '0;
                tg_q[i]  <= TG_DEFAULT;
            end
        end else begin
            car_q    <= car_now;
            tg_valid <= 1'b0;
            win_q    <= win_end ? 16'd0 : win_q + 16'd1;

            // A rise on the window-end edge belongs to the new window.
            for (int i = 0; i < NUM_APP; i++) begin
                if (win_end)
                    cnt_q[i] <= {7'd0, car_rise[i]};
                else if (car_rise[i] && cnt_q[i] != 8'hFF)
                    cnt_q[i] <= cnt_q[i] + 8'd1;
            end

            case (state_q)
                COUNT: begin
                    if (win_end) begin
                        for (int i = 0; i < NUM_APP; i++) begin
                            wgt_q[i] <= cnt_q[i];
                            acc_q[i] <= TG_MIN_W8;
                        end
                        all_zero_q <= ((cnt_q[0] | cnt_q[1] | cnt_q[2] | cnt_q[3]) == 8'd0);
                        unit_q     <= '0;
                    end
                end
                ALLOC: begin
                    acc_q[win_idx] <= acc_q[win_idx] + UNIT_W8;
                    wgt_q[win_idx] <= wgt_q[win_idx] >> 1;
                    unit_q         <= unit_q + 3'd1;
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_APP; i++)
                        tg_q[i] <= all_zero_q ? TG_DEFAULT : acc_q[i];
                    tg_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign TGn = tg_q[N];
    assign TGe = tg_q[E];
    assign TGs = tg_q[S];
    assign TGw = tg_q[W];

`else

    logic unused_cars;
    localparam int unused_win_len = WIN_LEN;

    assign unused_cars = ^{car_n, car_e, car_s, car_w};
    assign TGn         = TG_DEFAULT;
    assign TGe         = TG_DEFAULT;
    assign TGs         = TG_DEFAULT;
    assign TGw         = TG_DEFAULT;
    assign tg_valid    = 1'b0;

`endif

endmodule

// File: doc/traffic_demand_ctrl.md
# traffic_demand_ctrl

Front-end conditioner for the four-way traffic light controller. It debounces the raw pedestrian and emergency push-buttons into clean single-cycle request pulses. It also measures vehicle demand per approach over a fixed window and computes the four green durations (TGn/TGe/TGs/TGw). It drives the controller's ped_button, em_button and TGx inputs and sits between board I/O and the light FSM.

## Interface
- TCYCLE, 200, total cycle length in ticks
- TO, 10, orange duration per approach in ticks
- TG_MIN, 20, minimum green per approach
- DEB_CYCLES, 4, consecutive stable cycles required by the debouncer (range 2–255)
- WIN_LEN, 200, demand window length in clk cycles (range 16–65535)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ped_raw  input  1  raw pedestrian button, may bounce
- em_raw  input  1  raw emergency button, may bounce
- car_n, car_e, car_s, car_w  input  1 each  vehicle detector outputs, high while a vehicle is present
- ped_button  output  1  one-cycle pedestrian request pulse
- em_button  output  1  one-cycle emergency request pulse
- TGn, TGe, TGs, TGw  output  8 each  green durations in ticks
- tg_valid  output  1  one-cycle strobe, high the cycle the TGx outputs take new values

## Operation
- Reset values: ped_button=0, em_button=0, tg_valid=0, TGn=TGe=TGs=TGw=40. All counters are cleared and the FSM is in COUNT.
- Debouncer, one instance per button:
  - A press is accepted when the raw input has been high for DEB_CYCLES consecutive cycles. The output then pulses high for exactly one cycle.
  - The debouncer re-arms only after the raw input has been low for DEB_CYCLES consecutive cycles.
  - A held button produces one pulse. A glitch shorter than DEB_CYCLES produces none.
  - ped and em are independent. Simultaneous presses give simultaneous pulses.
- Vehicle counting:
  - Each car_x is registered. A rising edge increments that approach's 8-bit counter, which saturates at 255.
  - A level held high counts once.
- Window: a 16-bit counter wraps at WIN_LEN-1. On the wrap edge the four counts are snapshotted into weights and the live counters are cleared.
  - A rising edge on that same edge counts into the new window, so the live counter becomes 1.
  - The window counter keeps running during allocation.
- Allocation budget: G = TCYCLE − 4·TO = 160. Each approach starts at TG_MIN, which uses 80. The remaining 80 are split into 8 units of 10.
- FSM states:
  - COUNT: waiting for a window end.
  - ALLOC: 8 cycles, unit index 0..7. Each cycle the approach with the largest weight gets +10, and that weight is then shifted right by 1. Ties go to the lowest index, in the order N, E, S, W.
  - COMMIT: 1 cycle. Writes TGx and pulses tg_valid, then returns to COUNT.
- All-zero snapshot: ALLOC still runs for 8 cycles. COMMIT writes 40 to every approach.
- The TGx sum is always exactly 160. Maximum single value is 100, which fits in 8 bits.
- A window end while in ALLOC or COMMIT cannot occur because WIN_LEN ≥ 16.

## Timing
- Button latency: the pulse is asserted on the DEB_CYCLES-th rising clk edge at which the sampled raw input is high. That is the DEB_CYCLES-th consecutive high sample, since the raw input is registered once.
- Demand latency: snapshot edge E0, ALLOC on E1..E8, COMMIT on E9. TGx change and tg_valid rises after E9. tg_valid is high for exactly one cycle.
- TGx are registered and all four change on the same edge. Between commits they hold their value.
- Reset asserted mid-ALLOC aborts the allocation:
  - TGx return to 40 on the next edge.
  - The pending result is discarded.
  - tg_valid does not pulse.
- Reset overrides all events in the same cycle.

## Configuration
- TDC_ADAPTIVE_EN defined: vehicle counters, the window counter and the allocation FSM are built as described above.
- TDC_ADAPTIVE_EN undefined: the demand logic is not compiled. TGx are constant 40 and tg_valid is tied to 0. car_x are ignored. The debouncers are unaffected.

## Structure
- Shared package traffic_pkg holds:
  - TCYCLE, TO and TG_DEFAULT (40)
  - the approach index enum {N, E, S, W}
  - the FSM state enum {COUNT, ALLOC, COMMIT}
- Sub-module btn_debounce (parameter DEB_CYCLES; ports clk, reset, raw, pulse) is instantiated twice.

## Test plan
- Reset: assert reset for 2 cycles -> all outputs at reset values, TGx=40, no pulses.
- Debounce: with DEB_CYCLES=4, apply a 3-cycle high glitch -> no pulse. Then hold high for 20 cycles -> exactly one em_button pulse, asserted on the 4th rising edge with the input sampled high. Release, then re-press -> one more pulse.
- Weighted allocation: one window with N=8, E=4, S=2, W=0 car edges -> 9 edges after the wrap edge, TGn=60, TGe=50, TGs=30, TGw=20, tg_valid pulses once.
- Zero demand: a window with no cars -> TGx=40,40,40,40 at COMMIT, tg_valid pulses.
- Saturation: 300 N rising edges in one window, none elsewhere -> N weight 255, TGn=100, TGe=TGs=TGw=20.
- Reset mid-ALLOC: assert reset at E4 -> TGx=40 on the next edge, no tg_valid. Next window allocates normally.
